// File: rtl/bcp_clause_sched.sv
// bcp_clause_sched: BCP clause scan sequencer.
// Holds the current partial assignment and a small clause store. Every
// accepted assignment triggers one pass over all clauses. Unit clauses are
// reported as implications over a valid/ready handshake. The first
// conflicting clause aborts the pass.
// Optional feature macro: BCP_AUTO_IMPLY_EN. When it is defined, each
// accepted implication is also written into the assignment state, so later
// clauses in the same pass see it.

// Literal cell: the literal is true when the variable matches its polarity.
// en gates the output with "variable present and known".
module nox_and (
    input  logic a,
    input  logic b,
    input  logic en,
    output logic y
);
    assign y = en & ~(a ^ b);
endmodule

module bcp_clause_sched #(
    parameter int NUM_VARS    = 8,
    parameter int NUM_CLAUSES = 16,
    localparam int VW = $clog2(NUM_VARS),
    localparam int CW = $clog2(NUM_CLAUSES)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_we,
    input  logic [CW-1:0]       cfg_addr,
    input  logic [NUM_VARS-1:0] cfg_type,
    input  logic [NUM_VARS-1:0] cfg_mask,
    input  logic                asg_valid,
    output logic                asg_ready,
    input  logic [VW-1:0]       asg_var,
    input  logic                asg_val,
    input  logic                clr,
    output logic                imp_valid,
    input  logic                imp_ready,
    output logic [VW-1:0]       imp_var,
    output logic                imp_val,
    output logic [CW-1:0]       imp_clause,
    output logic                conflict,
    output logic [CW-1:0]       conflict_clause,
    output logic                scan_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    localparam logic [NUM_VARS-1:0] ONE_V    = NUM_VARS'(1);
    localparam logic [CW:0]         LAST_PTR = (CW+1)'(NUM_CLAUSES - 1);
    localparam logic [CW:0]         ONE_PTR  = (CW+1)'(1);

    state_t                state_reg;
    logic [NUM_VARS-1:0]   known_reg;
    logic [NUM_VARS-1:0]   value_reg;
    logic [CW:0]           ptr_reg;
    logic                  asg_ready_reg;
    logic                  imp_valid_reg;
    logic [VW-1:0]         imp_var_reg;
    logic                  imp_val_reg;
    logic [CW-1:0]         imp_clause_reg;
    logic                  conflict_reg;
    logic [CW-1:0]         conflict_clause_reg;
    logic                  scan_done_reg;

    logic [NUM_VARS-1:0]   type_mem [NUM_CLAUSES];
    logic [NUM_VARS-1:0]   mask_mem [NUM_CLAUSES];

    logic [NUM_VARS-1:0]   cur_type;
    logic [NUM_VARS-1:0]   cur_mask;
    logic [NUM_VARS-1:0]   sat_vec;
    logic [NUM_VARS-1:0]   free_vec;
    logic                  any_sat;
    logic                  no_free;
    logic                  one_free;
    logic                  last_clause;
    logic [VW-1:0]         free_idx;

    assign cur_type = type_mem[ptr_reg[CW-1:0]];
    assign cur_mask = mask_mem[ptr_reg[CW-1:0]];

    // One literal cell per variable; a variable with no known value is free.
    generate
        for (genvar gi = 0; gi < NUM_VARS; gi++) begin : g_lit
            nox_and u_lit (
                .a  (value_reg[gi]),
                .b  (cur_type[gi]),
                .en (cur_mask[gi] & known_reg[gi]),
                .y  (sat_vec[gi])
            );
            assign free_vec[gi] = cur_mask[gi] & ~known_reg[gi];
        end
    endgenerate

    assign any_sat     = |sat_vec;
    assign no_free     = (free_vec == '0);
    assign one_free    = !no_free && ((free_vec & (free_vec - ONE_V)) == '0);
    assign last_clause = (ptr_reg == LAST_PTR);

    // Locate the free literal. It is only used when exactly one is free.
    always_comb begin
        free_idx = '0;
        for (int i = 0; i < NUM_VARS; i++) begin
            if (free_vec[i]) free_idx = VW'(i);
        end
    end

    // Clause store: writable only while no scan is in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CLAUSES; i++) begin
                type_mem[i] <= '0;
                mask_mem[i] <= '0;
            end
        end else if (cfg_we && state_reg == ST_IDLE) begin
            type_mem[cfg_addr] <= cfg_type;
            mask_mem[cfg_addr] <= cfg_mask;
        end
    end

    // Scan FSM with the assignment state and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg           <= ST_IDLE;
            known_reg           <= '0;
            value_reg           <= '0;
            ptr_reg             <= '0;
            asg_ready_reg       <= 1'b1;
            imp_valid_reg       <= 1'b0;
            imp_var_reg         <= '0;
            imp_val_reg         <= 1'b0;
            imp_clause_reg      <= '0;
            conflict_reg        <= 1'b0;
            conflict_clause_reg <= '0;
            scan_done_reg       <= 1'b0;
        end else begin
            conflict_reg  <= 1'b0;
            scan_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (clr) begin
                        // Backtrack to the root. A simultaneous assignment is dropped.
                        known_reg <= '0;
                        value_reg <= '0;
                    end else if (asg_valid) begin
                        known_reg[asg_var] <= 1'b1;
                        value_reg[asg_var] <= asg_val;
                        ptr_reg            <= '0;
                        asg_ready_reg      <= 1'b0;
                        state_reg          <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (any_sat || (!no_free && !one_free)) begin
                        // The clause is SAT or OPEN, so it needs no action.
                        if (last_clause) begin
                            scan_done_reg <= 1'b1;
                            asg_ready_reg <= 1'b1;
                            state_reg     <= ST_IDLE;
                        end else begin
                            ptr_reg <= ptr_reg + ONE_PTR;
                        end
                    end else if (one_free) begin
                        imp_valid_reg  <= 1'b1;
                        imp_var_reg    <= free_idx;
                        imp_val_reg    <= cur_type[free_idx];
                        imp_clause_reg <= ptr_reg[CW-1:0];
                        state_reg      <= ST_EMIT;
                    end else begin
                        conflict_reg        <= 1'b1;
                        conflict_clause_reg <= ptr_reg[CW-1:0];
                        asg_ready_reg       <= 1'b1;
                        state_reg           <= ST_IDLE;
                    end
                end
                ST_EMIT: begin
                    if (imp_ready) begin
                        imp_valid_reg <= 1'b0;
`ifdef BCP_AUTO_IMPLY_EN
                        known_reg[imp_var_reg] <= 1'b1;
                        value_reg[imp_var_reg] <= imp_val_reg;
`endif
                        if (last_clause) begin
                            scan_done_reg <= 1'b1;
                            asg_ready_reg <= 1'b1;
                            state_reg     <= ST_IDLE;
                        end else begin
                            ptr_reg   <= ptr_reg + ONE_PTR;
                            state_reg <= ST_SCAN;
                        end
                    end
                end
                default: begin
                    asg_ready_reg <= 1'b1;
                    state_reg     <= ST_IDLE;
                end
            endcase
        end
    end

    assign asg_ready       = asg_ready_reg;
    assign imp_valid       = imp_valid_reg;
    assign imp_var         = imp_var_reg;
    assign imp_val         = imp_val_reg;
    assign imp_clause      = imp_clause_reg;
    assign conflict        = conflict_reg;
    assign conflict_clause = conflict_clause_reg;
    assign scan_done       = scan_done_reg;

endmodule

// File: tb/tb_bcp_clause_sched.sv
// Testbench for bcp_clause_sched. A pass-level clause evaluator predicts the
// implications and the pass outcome for every assignment. The bench checks
// the DUT against that prediction cycle by cycle during each pass.
module tb_bcp_clause_sched;
    localparam int NV = 8;
    localparam int NC = 16;
    localparam int VW = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic [CW-1:0] cfg_addr = '0;
    logic [NV-1:0] cfg_type = '0;
    logic [NV-1:0] cfg_mask = '0;
    logic          asg_valid = 1'b0;
    logic          asg_ready;
    logic [VW-1:0] asg_var = '0;
    logic          asg_val = 1'b0;
    logic          clr = 1'b0;
    logic          imp_valid;
    logic          imp_ready = 1'b1;
    logic [VW-1:0] imp_var;
    logic          imp_val;
    logic [CW-1:0] imp_clause;
    logic          conflict;
    logic [CW-1:0] conflict_clause;
    logic          scan_done;

    bcp_clause_sched #(.NUM_VARS(NV), .NUM_CLAUSES(NC)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_type(cfg_type), .cfg_mask(cfg_mask),
        .asg_valid(asg_valid), .asg_ready(asg_ready), .asg_var(asg_var), .asg_val(asg_val),
        .clr(clr),
        .imp_valid(imp_valid), .imp_ready(imp_ready), .imp_var(imp_var), .imp_val(imp_val),
        .imp_clause(imp_clause),
        .conflict(conflict), .conflict_clause(conflict_clause), .scan_done(scan_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit auto_en;

    // Reference state: assignment and clause store.
    bit            m_known [NV];
    bit            m_value [NV];
    logic [NV-1:0] m_type  [NC];
    logic [NV-1:0] m_mask  [NC];

    typedef struct {
        int c;
        int v;
        int val;
    } imp_t;
    imp_t exp_q[$];
    bit   exp_conf;
    int   exp_cc;

    // Observations from the most recent pass, used for literal pins.
    int last_k;
    int last_nimp;
    int first_imp_var;
    int first_imp_val;
    int first_imp_clause;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d @%0t", name, act, req, $time);
        end
    endtask

    // Evaluate every clause in order and list the expected implications and outcome.
    task automatic model_scan();
        exp_q.delete();
        exp_conf = 1'b0;
        exp_cc   = 0;
        for (int c = 0; c < NC; c++) begin
            int nsat = 0;
            int nfree = 0;
            int fv = 0;
            for (int v = 0; v < NV; v++) begin
                if (m_mask[c][v]) begin
                    if (!m_known[v]) begin
                        nfree++;
                        fv = v;
                    end else if (m_value[v] == m_type[c][v]) begin
                        nsat++;
                    end
                end
            end
            if (nsat > 0) continue;
            if (nfree == 0) begin
                exp_conf = 1'b1;
                exp_cc   = c;
                break;
            end
            if (nfree == 1) begin
                exp_q.push_back('{c, fv, int'(m_type[c][fv])});
                if (auto_en) begin
                    m_known[fv] = 1'b1;
                    m_value[fv] = m_type[c][fv];
                end
            end
        end
    endtask

    task automatic write_clause(input int c, input logic [NV-1:0] t, input logic [NV-1:0] m);
        cfg_addr = CW'(c);
        cfg_type = t;
        cfg_mask = m;
        cfg_we   = 1'b1;
        @(negedge clk);
        cfg_we   = 1'b0;
        m_type[c] = t;
        m_mask[c] = m;
    endtask

    // Filler clause (x6 | x7): these variables are never assigned, so it stays OPEN.
    task automatic init_store();
        for (int c = 0; c < NC; c++) write_clause(c, 8'hC0, 8'hC0);
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_known[v] = 1'b0;
            m_value[v] = 1'b0;
        end
    endtask

    // clr together with asg_valid: the clear takes effect and the assignment is dropped.
    task automatic clr_task();
        clr = 1'b1;
        asg_var = 3'd4;
        asg_val = 1'b1;
        asg_valid = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        asg_valid = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            chk("clr_asg_ready", asg_ready, 1);
            chk("clr_no_scan_done", scan_done, 0);
            chk("clr_no_imp", imp_valid, 0);
            @(negedge clk);
        end
    endtask

    // One assignment and the complete pass it starts.
    task automatic do_assign(input int v, input bit val, input int stall);
        int k;
        int emits;
        int nimp_exp;
        int nimp_seen;
        int stall_left;
        bit pending;
        bit finished;
        logic [31:0] h_var;
        logic [31:0] h_val;
        logic [31:0] h_cl;
        chk("asg_ready_idle", asg_ready, 1);
        m_known[v] = 1'b1;
        m_value[v] = val;
        model_scan();
        nimp_exp = exp_q.size();
        asg_var = VW'(v);
        asg_val = val;
        asg_valid = 1'b1;
        imp_ready = 1'b1;
        @(negedge clk);
        asg_valid = 1'b0;
        k = 1; emits = 0; nimp_seen = 0; stall_left = 0;
        pending = 1'b0; finished = 1'b0;
        h_var = 0; h_val = 0; h_cl = 0;
        while (!finished && k <= 300) begin
            if (conflict) begin
                chk("outcome_conflict", conflict, exp_conf);
                chk("conflict_clause", conflict_clause, exp_cc);
                chk("conflict_cycle", k, 2 + exp_cc + emits);
                chk("conflict_asg_ready", asg_ready, 1);
                chk("conflict_no_done", scan_done, 0);
                finished = 1'b1;
            end else if (scan_done) begin
                chk("outcome_done", conflict, exp_conf);
                chk("done_cycle", k, 17 + emits);
                chk("done_asg_ready", asg_ready, 1);
                finished = 1'b1;
            end else begin
                chk("busy_asg_ready", asg_ready, 0);
                if (imp_valid) begin
                    emits++;
                    if (!pending) begin
                        nimp_seen++;
                        pending = 1'b1;
                        stall_left = stall;
                        h_var = imp_var; h_val = imp_val; h_cl = imp_clause;
                        if (nimp_seen == 1) begin
                            first_imp_var = imp_var;
                            first_imp_val = imp_val;
                            first_imp_clause = imp_clause;
                        end
                        if (exp_q.size() > 0) begin
                            chk("imp_var", imp_var, exp_q[0].v);
                            chk("imp_val", imp_val, exp_q[0].val);
                            chk("imp_clause", imp_clause, exp_q[0].c);
                        end
                    end else begin
                        chk("imp_var_stable", imp_var, h_var);
                        chk("imp_val_stable", imp_val, h_val);
                        chk("imp_clause_stable", imp_clause, h_cl);
                    end
                    if (stall_left > 0) begin
                        imp_ready = 1'b0;
                        stall_left--;
                    end else begin
                        imp_ready = 1'b1;
                        pending = 1'b0;
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                    end
                end else begin
                    imp_ready = 1'b1;
                end
            end
            if (!finished) begin
                @(negedge clk);
                k++;
            end
        end
        chk("scan_finished", finished, 1);
        chk("imp_count", nimp_seen, nimp_exp);
        last_k = k;
        last_nimp = nimp_seen;
        imp_ready = 1'b1;
        @(negedge clk);
        chk("pulse_conflict_low", conflict, 0);
        chk("pulse_done_low", scan_done, 0);
        chk("post_imp_valid", imp_valid, 0);
        chk("post_asg_ready", asg_ready, 1);
    endtask

    initial begin
`ifdef BCP_AUTO_IMPLY_EN
        auto_en = 1'b1;
`else
        auto_en = 1'b0;
`endif
        model_reset();
        for (int c = 0; c < NC; c++) begin
            m_type[c] = '0;
            m_mask[c] = '0;
        end
        last_k = 0; last_nimp = 0;
        first_imp_var = 0; first_imp_val = 0; first_imp_clause = 0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_asg_ready", asg_ready, 1);
        chk("rst_imp_valid", imp_valid, 0);
        chk("rst_imp_var", imp_var, 0);
        chk("rst_imp_val", imp_val, 0);
        chk("rst_imp_clause", imp_clause, 0);
        chk("rst_conflict", conflict, 0);
        chk("rst_conflict_clause", conflict_clause, 0);
        chk("rst_scan_done", scan_done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: clause 0 = (x0 | ~x1). x0 = 0 implies x1 = 0.
        init_store();
        write_clause(0, 8'h01, 8'h03);
        do_assign(0, 1'b0, 0);
        chk("t1_nimp", last_nimp, 1);
        chk("t1_imp_var", first_imp_var, 1);
        chk("t1_imp_val", first_imp_val, 0);
        chk("t1_imp_clause", first_imp_clause, 0);
        chk("t1_done_cycle", last_k, 18);

        // T2: then x1 = 1 falsifies clause 0.
        do_assign(1, 1'b1, 0);
        chk("t2_conflict_cycle", last_k, 2);
        chk("t2_conflict_clause", conflict_clause, 0);

        // T3: imp_ready held low for 5 EMIT cycles.
        clr_task();
        do_assign(0, 1'b0, 5);
        chk("t3_nimp", last_nimp, 1);
        chk("t3_done_cycle", last_k, 23);

        // T4: clr drops the old assignments. Empty clause 3 then conflicts.
        clr_task();
        write_clause(3, 8'h00, 8'h00);
        do_assign(5, 1'b1, 0);
        chk("t4_conflict_cycle", last_k, 5);
        chk("t4_conflict_clause", conflict_clause, 3);

        // T5: chain (x0 | x1), (~x1 | x2).
        clr_task();
        write_clause(3, 8'hC0, 8'hC0);
        write_clause(0, 8'h03, 8'h03);
        write_clause(1, 8'h04, 8'h06);
        do_assign(0, 1'b0, 0);
        chk("t5_nimp", last_nimp, auto_en ? 2 : 1);
        chk("t5_first_var", first_imp_var, 1);
        chk("t5_first_val", first_imp_val, 1);
        chk("t5_done_cycle", last_k, auto_en ? 19 : 18);

        // T6: asynchronous reset while an implication is pending.
        clr_task();
        write_clause(0, 8'h01, 8'h03);
        asg_var = 3'd0;
        asg_val = 1'b0;
        asg_valid = 1'b1;
        @(negedge clk);
        asg_valid = 1'b0;
        imp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t6_pre_imp_valid", imp_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_imp_valid", imp_valid, 0);
        chk("t6_rst_asg_ready", asg_ready, 1);
        chk("t6_rst_imp_var", imp_var, 0);
        @(negedge clk);
        rst_n = 1'b1;
        imp_ready = 1'b1;
        model_reset();
        for (int c = 0; c < NC; c++) begin
            m_type[c] = '0;
            m_mask[c] = '0;
        end
        chk("t6_conflict_clause", conflict_clause, 0);
        init_store();
        write_clause(0, 8'h01, 8'h03);
        do_assign(2, 1'b1, 0);
        chk("t6_nimp", last_nimp, 0);
        chk("t6_done_cycle", last_k, 17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcp_clause_sched.md
# bcp_clause_sched

Sequencer for the hardware BCP datapath: holds the current variable assignment and a clause store, and scans every clause once per accepted assignment. Each clause is evaluated through a row of NUM_VARS `nox_and` literal cells. For each clause the block reports unit implications over a valid/ready handshake, or aborts the scan on the first conflict. It sits between the search/decision logic (assignment and backtrack source) and the implication consumer.

## Interface
Parameters:
- NUM_VARS, 8, variables per clause row; VW = $clog2(NUM_VARS)
- NUM_CLAUSES, 16, clause store depth; CW = $clog2(NUM_CLAUSES)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  clause write strobe, honoured only in IDLE
- cfg_addr  in  CW  clause index
- cfg_type  in  NUM_VARS  literal polarity per variable (1 = positive literal)
- cfg_mask  in  NUM_VARS  variable present in clause
- asg_valid  in  1  assignment request
- asg_ready  out  1  high only in IDLE
- asg_var  in  VW  variable index
- asg_val  in  1  assigned value
- clr  in  1  clear all assignments (backtrack to root), honoured only in IDLE
- imp_valid  out  1  implication available
- imp_ready  in  1  implication consumer accepts
- imp_var  out  VW  implied variable
- imp_val  out  1  implied value (= cfg_type bit of the free literal)
- imp_clause  out  CW  source clause
- conflict  out  1  one-cycle pulse, all literals of a clause false
- conflict_clause  out  CW  conflicting clause index, held until the next scan starts
- scan_done  out  1  one-cycle pulse, scan completed without conflict

## Operation
- State: known[NUM_VARS], value[NUM_VARS], clause store type/mask[NUM_CLAUSES], clause pointer ptr (CW+1 bits).
- Literal i of clause c: sat = mask & known & ~(value ^ type), i.e. the `nox_and` output gated by known; false = mask & known & (value ^ type); free = mask & ~known.
- Clause status: SAT if any sat; otherwise CONFLICT if zero free, UNIT if exactly one free, OPEN if two or more free. Empty clause (mask = 0) is CONFLICT.
- FSM:
  - IDLE: asg_ready = 1. On asg_valid, set known[asg_var] = 1 and value[asg_var] = asg_val, set ptr = 0, go to SCAN. When clr and asg_valid are both high, clr wins, the assignment is dropped, and asg_ready stays high.
  - SCAN: evaluate clause ptr in one cycle.
    - SAT or OPEN: ptr+1.
    - UNIT: go to EMIT.
    - CONFLICT: pulse conflict, go to IDLE.
    - After clause NUM_CLAUSES-1 with no conflict: pulse scan_done, go to IDLE.
  - EMIT: imp_valid = 1, with imp_var/imp_val/imp_clause stable. On imp_valid & imp_ready: ptr+1, back to SCAN, or IDLE with scan_done if ptr was the last clause.
- Reassigning an already-known variable overwrites its value and rescans.
- cfg_we and clr outside IDLE are ignored.
- Reset values: known = 0, value = 0, clause store mask = 0 and type = 0, state IDLE, asg_ready = 1, imp_valid = 0, imp_var = 0, imp_val = 0, imp_clause = 0, conflict = 0, conflict_clause = 0, scan_done = 0.
- Reset mid-scan or mid-EMIT: immediate return to IDLE with all of the above cleared. A pending implication is lost.

## Timing
- Assignment accepted at edge T: clause 0 is evaluated in cycle T+1.
- Each SAT/OPEN clause costs one cycle.
- Each UNIT clause costs one SCAN cycle plus at least one EMIT cycle. EMIT lasts until imp_ready is high.
- scan_done is asserted in cycle T+1+NUM_CLAUSES+(EMIT cycles). asg_ready returns high in that same cycle.
- conflict is asserted in the cycle after the conflicting clause's SCAN cycle.
- imp_* outputs are registered and must not change while imp_valid & ~imp_ready.

## Configuration
- BCP_AUTO_IMPLY_EN defined: each accepted implication also sets known/value for imp_var on the handshake edge, so later clauses in the same scan see it. If a later clause becomes CONFLICT because of it, conflict is raised normally.
- BCP_AUTO_IMPLY_EN undefined: implications are reported only, and assignment state changes only through asg_* and clr.

## Test plan
- Store clause 0 = (x0 | ~x1): mask 0x03, type 0x01. Assign x0 = 0 -> imp_valid with imp_var 1, imp_val 0, imp_clause 0; then scan_done at T+1+16+1 with imp_ready tied high.
- Same clause, assign x0 = 0 then x1 = 1 -> conflict pulse with conflict_clause 0, no scan_done, asg_ready high in the next cycle.
- Hold imp_ready low for 5 cycles during EMIT -> imp_* held stable for all 5 cycles, ptr frozen, single acceptance.
- Assert clr together with asg_valid in IDLE -> known = 0, assignment dropped, no scan; then mask = 0 clause 3 with any assignment -> conflict_clause 3.
- Chain clause 0 = (x0 | x1), clause 1 = (~x1 | x2); assign x0 = 0 -> implication x1 = 1. With BCP_AUTO_IMPLY_EN, a second implication follows: x2 = 1 from clause 1. Without the macro, no second implication.
- Pull rst_n low during EMIT -> imp_valid drops asynchronously, state IDLE, known cleared, asg_ready = 1.
